// File: rtl/idex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: control bundle,
// ALU operation encoding and the all-zero bubble constant.
package idex_reg_pkg;

    localparam int DEF_XLEN          = 32;
    localparam int DEF_RF_ADDR_WIDTH = 5;
    localparam int DEF_CNT_WIDTH     = 16;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic    regWrite;
        logic    memRead;
        logic    memWrite;
        logic    memToReg;
        logic    aluSrc;
        logic    branch;
        logic    jump;
        alu_op_e aluOp;
    } idex_ctrl_t;

    // A bubble carries no side effects: no register write, no memory access.
    localparam idex_ctrl_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/idex_reg_hazard.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently sitting in EX. Kept separate so a later
// branch-in-ID dependency check can reuse it.
module idex_hazard #(
    parameter int RF_ADDR_WIDTH = 5
) (
    input  logic                     idValid_i,
    input  logic [RF_ADDR_WIDTH-1:0] idRs1_i,
    input  logic [RF_ADDR_WIDTH-1:0] idRs2_i,
    input  logic                     idUsesRs1_i,
    input  logic                     idUsesRs2_i,
    input  logic                     exValid_i,
    input  logic                     exMemRead_i,
    input  logic [RF_ADDR_WIDTH-1:0] exRd_i,
    input  logic                     flush_i,
    output logic                     loadUse_o,
    output logic                     hazStall_o
);

    logic rs1Match;
    logic rs2Match;

    // Compare the operands ID really reads against the load destination in EX;
    // x0 is never a real dependency, and a flush kills the stall request.
    always_comb begin
        rs1Match   = idUsesRs1_i && (idRs1_i == exRd_i);
        rs2Match   = idUsesRs2_i && (idRs2_i == exRd_i);
        loadUse_o  = idValid_i && exValid_i && exMemRead_i &&
                     (exRd_i != '0) && (rs1Match || rs2Match);
        hazStall_o = loadUse_o && !flush_i;
    end

endmodule

// File: rtl/idex_reg.sv
// ID/EX pipeline register with integrated load-use bubble insertion,
// branch flush, MEM-driven freeze and saturating stall/flush counters.
module idex_reg
    import idex_reg_pkg::*;
#(
    parameter int XLEN          = DEF_XLEN,
    parameter int RF_ADDR_WIDTH = DEF_RF_ADDR_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     idValid,
    input  logic [XLEN-1:0]          idPc,
    input  logic [XLEN-1:0]          idRs1Data,
    input  logic [XLEN-1:0]          idRs2Data,
    input  logic [XLEN-1:0]          idImm,
    input  logic [RF_ADDR_WIDTH-1:0] idRs1,
    input  logic [RF_ADDR_WIDTH-1:0] idRs2,
    input  logic [RF_ADDR_WIDTH-1:0] idRd,
    input  logic                     idUsesRs1,
    input  logic                     idUsesRs2,
    input  idex_ctrl_t               idCtrl,
    input  logic                     exFlush,
    input  logic                     memStall,
    output logic                     idexValid,
    output logic [XLEN-1:0]          idexPc,
    output logic [XLEN-1:0]          idexRs1Data,
    output logic [XLEN-1:0]          idexRs2Data,
    output logic [XLEN-1:0]          idexImm,
    output logic [RF_ADDR_WIDTH-1:0] idexRs1,
    output logic [RF_ADDR_WIDTH-1:0] idexRs2,
    output logic [RF_ADDR_WIDTH-1:0] idexRd,
    output idex_ctrl_t               idexCtrl,
    output logic                     hazStall,
    output logic [CNT_WIDTH-1:0]     stallCount,
    output logic [CNT_WIDTH-1:0]     flushCount
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                     valid_q,    valid_d;
    logic [XLEN-1:0]          pc_q,       pc_d;
    logic [XLEN-1:0]          rs1Data_q,  rs1Data_d;
    logic [XLEN-1:0]          rs2Data_q,  rs2Data_d;
    logic [XLEN-1:0]          imm_q,      imm_d;
    logic [RF_ADDR_WIDTH-1:0] rs1_q,      rs1_d;
    logic [RF_ADDR_WIDTH-1:0] rs2_q,      rs2_d;
    logic [RF_ADDR_WIDTH-1:0] rd_q,       rd_d;
    idex_ctrl_t               ctrl_q,     ctrl_d;
    logic [CNT_WIDTH-1:0]     stallCnt_q, stallCnt_d;
    logic [CNT_WIDTH-1:0]     flushCnt_q, flushCnt_d;
    logic                     loadUse;

    idex_hazard #(
        .RF_ADDR_WIDTH (RF_ADDR_WIDTH)
    ) u_hazard (
        .idValid_i   (idValid),
        .idRs1_i     (idRs1),
        .idRs2_i     (idRs2),
        .idUsesRs1_i (idUsesRs1),
        .idUsesRs2_i (idUsesRs2),
        .exValid_i   (valid_q),
        .exMemRead_i (ctrl_q.memRead),
        .exRd_i      (rd_q),
        .flush_i     (exFlush),
        .loadUse_o   (loadUse),
        .hazStall_o  (hazStall)
    );

    // Next-state selection: freeze beats flush, flush beats load-use bubble,
    // otherwise capture ID (with control/addresses zeroed for a non-instruction).
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1Data_d  = rs1Data_q;
        rs2Data_d  = rs2Data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;

        if (memStall) begin
            valid_d = valid_q;
        end else if (exFlush || loadUse) begin
            valid_d   = 1'b0;
            pc_d      = '0;
            rs1Data_d = '0;
            rs2Data_d = '0;
            imm_d     = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_d      = '0;
            ctrl_d    = IDEX_BUBBLE;
            if (exFlush) begin
                flushCnt_d = (flushCnt_q == CNT_MAX) ? flushCnt_q : flushCnt_q + CNT_ONE;
            end else begin
                stallCnt_d = (stallCnt_q == CNT_MAX) ? stallCnt_q : stallCnt_q + CNT_ONE;
            end
        end else begin
            valid_d   = idValid;
            pc_d      = idPc;
            rs1Data_d = idRs1Data;
            rs2Data_d = idRs2Data;
            imm_d     = idImm;
            rs1_d     = idValid ? idRs1 : '0;
            rs2_d     = idValid ? idRs2 : '0;
            rd_d      = idValid ? idRd  : '0;
            ctrl_d    = idValid ? idCtrl : IDEX_BUBBLE;
        end
    end

    // State register with synchronous reset that overrides every other action.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1Data_q  <= '0;
            rs2Data_q  <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= IDEX_BUBBLE;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1Data_q  <= rs1Data_d;
            rs2Data_q  <= rs2Data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign idexValid   = valid_q;
    assign idexPc      = pc_q;
    assign idexRs1Data = rs1Data_q;
    assign idexRs2Data = rs2Data_q;
    assign idexImm     = imm_q;
    assign idexRs1     = rs1_q;
    assign idexRs2     = rs2_q;
    assign idexRd      = rd_q;
    assign idexCtrl    = ctrl_q;
    assign stallCount  = stallCnt_q;
    assign flushCount  = flushCnt_q;

endmodule

// File: tb/tb_idex_reg.sv
// Scoreboard bench for idex_reg: directed ID-stage vectors with hand-chosen
// outcomes, plus a 2-bit-counter instance to reach saturation quickly.
module tb_idex_reg;
    import idex_reg_pkg::*;

    localparam int ACT_RESET   = 0;
    localparam int ACT_LOAD    = 1;
    localparam int ACT_LOADINV = 2;
    localparam int ACT_BUBBLE  = 3;
    localparam int ACT_HOLD    = 4;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        idex_ctrl_t  ctrl;
        int          stallC, flushC;
        int          haz;
        int          step;
    } exp_t;

    logic        clk, rst, idValid, idUsesRs1, idUsesRs2, exFlush, memStall;
    logic [31:0] idPc, idRs1Data, idRs2Data, idImm;
    logic [4:0]  idRs1, idRs2, idRd;
    idex_ctrl_t  idCtrl;

    logic        idexValid, hazStall;
    logic [31:0] idexPc, idexRs1Data, idexRs2Data, idexImm;
    logic [4:0]  idexRs1, idexRs2, idexRd;
    idex_ctrl_t  idexCtrl;
    logic [15:0] stallCount, flushCount;

    logic        sValid, sHazStall;
    logic [31:0] sPc, sRs1Data, sRs2Data, sImm;
    logic [4:0]  sRs1, sRs2, sRd;
    idex_ctrl_t  sCtrl;
    logic [1:0]  sStallCount, sFlushCount;

    int   checks = 0;
    int   errors = 0;
    int   stepNo = 0;
    exp_t sb[$];
    exp_t lastExp;
    idex_ctrl_t ctrlAlu, ctrlLoad;

    idex_reg dut (
        .clk(clk), .rst(rst), .idValid(idValid), .idPc(idPc),
        .idRs1Data(idRs1Data), .idRs2Data(idRs2Data), .idImm(idImm),
        .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .idCtrl(idCtrl),
        .exFlush(exFlush), .memStall(memStall),
        .idexValid(idexValid), .idexPc(idexPc),
        .idexRs1Data(idexRs1Data), .idexRs2Data(idexRs2Data), .idexImm(idexImm),
        .idexRs1(idexRs1), .idexRs2(idexRs2), .idexRd(idexRd),
        .idexCtrl(idexCtrl), .hazStall(hazStall),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    idex_reg #(.CNT_WIDTH(2)) dutSmall (
        .clk(clk), .rst(rst), .idValid(idValid), .idPc(idPc),
        .idRs1Data(idRs1Data), .idRs2Data(idRs2Data), .idImm(idImm),
        .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .idCtrl(idCtrl),
        .exFlush(exFlush), .memStall(memStall),
        .idexValid(sValid), .idexPc(sPc),
        .idexRs1Data(sRs1Data), .idexRs2Data(sRs2Data), .idexImm(sImm),
        .idexRs1(sRs1), .idexRs2(sRs2), .idexRd(sRd),
        .idexCtrl(sCtrl), .hazStall(sHazStall),
        .stallCount(sStallCount), .flushCount(sFlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input int step,
                               input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL step %0d %s: got %0h expected %0h", step, name, act, exp);
        end
    endtask

    // Drives one ID-stage vector and pushes the hand-chosen outcome for the next edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] pc,
                                 input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                                 input logic u1, input logic u2, input idex_ctrl_t c,
                                 input logic fl, input logic ms, input int act,
                                 input int hz, input int st, input int fc);
        exp_t e;
        rst = r; idValid = v; idPc = pc;
        idRs1Data = 32'hA000_0000 | pc; idRs2Data = 32'hB000_0000 | pc; idImm = 32'hC000_0000 | pc;
        idRs1 = a1; idRs2 = a2; idRd = d; idUsesRs1 = u1; idUsesRs2 = u2; idCtrl = c;
        exFlush = fl; memStall = ms;
        e = lastExp;
        if (act == ACT_LOAD || act == ACT_LOADINV) begin
            e.valid = (act == ACT_LOAD);
            e.pc = idPc; e.rs1d = idRs1Data; e.rs2d = idRs2Data; e.imm = idImm;
            e.rs1  = (act == ACT_LOAD) ? a1 : 5'd0;
            e.rs2  = (act == ACT_LOAD) ? a2 : 5'd0;
            e.rd   = (act == ACT_LOAD) ? d  : 5'd0;
            e.ctrl = (act == ACT_LOAD) ? c  : IDEX_BUBBLE;
        end else if (act != ACT_HOLD) begin
            e.valid = 1'b0; e.pc = '0; e.rs1d = '0; e.rs2d = '0; e.imm = '0;
            e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.ctrl = IDEX_BUBBLE;
        end
        e.stallC = st; e.flushC = fc; e.haz = hz; e.step = stepNo;
        stepNo++;
        lastExp = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples hazStall mid-cycle, then the registers after the edge.
    initial begin
        exp_t e;
        logic hs, shs;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                hs = hazStall;
                shs = sHazStall;
                @(posedge clk);
                #2;
                e = sb.pop_front();
                if (e.haz >= 0) begin
                    checkOutput("hazStall", e.step, hs, e.haz[0]);
                    checkOutput("small hazStall", e.step, shs, e.haz[0]);
                end
                checkOutput("idexValid", e.step, idexValid, e.valid);
                checkOutput("idexPc", e.step, idexPc, e.pc);
                checkOutput("idexRs1Data", e.step, idexRs1Data, e.rs1d);
                checkOutput("idexRs2Data", e.step, idexRs2Data, e.rs2d);
                checkOutput("idexImm", e.step, idexImm, e.imm);
                checkOutput("idexRs1", e.step, idexRs1, e.rs1);
                checkOutput("idexRs2", e.step, idexRs2, e.rs2);
                checkOutput("idexRd", e.step, idexRd, e.rd);
                checkOutput("idexCtrl", e.step, idexCtrl, e.ctrl);
                checkOutput("stallCount", e.step, stallCount, e.stallC[15:0]);
                checkOutput("flushCount", e.step, flushCount, e.flushC[15:0]);
                checkOutput("small fields", e.step,
                            {sValid, sPc, sRs1Data, sRs2Data, sImm, sRs1, sRs2, sRd, sCtrl},
                            {e.valid, e.pc, e.rs1d, e.rs2d, e.imm, e.rs1, e.rs2, e.rd, e.ctrl});
                checkOutput("small stallCount", e.step, sStallCount,
                            (e.stallC > 3) ? 2'd3 : e.stallC[1:0]);
                checkOutput("small flushCount", e.step, sFlushCount,
                            (e.flushC > 3) ? 2'd3 : e.flushC[1:0]);
            end
        end
    end

    // Directed sequence; argument order: rst valid pc rs1 rs2 rd uses1 uses2 ctrl flush memStall action haz stalls flushes.
    initial begin
        int st;
        int fc;
        ctrlAlu = IDEX_BUBBLE;  ctrlAlu.regWrite = 1'b1;  ctrlAlu.aluOp = ALU_ADD;
        ctrlLoad = IDEX_BUBBLE; ctrlLoad.regWrite = 1'b1; ctrlLoad.memRead = 1'b1;
        ctrlLoad.memToReg = 1'b1; ctrlLoad.aluSrc = 1'b1; ctrlLoad.aluOp = ALU_ADD;
        lastExp = '{default: 0, ctrl: IDEX_BUBBLE};
        rst = 1'b1; idValid = 1'b0; idPc = '0; idRs1Data = '0; idRs2Data = '0; idImm = '0;
        idRs1 = '0; idRs2 = '0; idRd = '0; idUsesRs1 = 1'b0; idUsesRs2 = 1'b0;
        idCtrl = IDEX_BUBBLE; exFlush = 1'b0; memStall = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 32'h000, 0, 0, 0, 0, 0, IDEX_BUBBLE, 0, 0, ACT_RESET, -1, 0, 0);
        // independent ALU ops
        applyStimulus(0, 1, 32'h100, 2, 3, 1, 1, 1, ctrlAlu,  0, 0, ACT_LOAD,   0, 0, 0);
        applyStimulus(0, 1, 32'h104, 5, 6, 4, 1, 1, ctrlAlu,  0, 0, ACT_LOAD,   0, 0, 0);
        // lw x5 then dependent add: one bubble, then the add loads
        applyStimulus(0, 1, 32'h108, 1, 0, 5, 1, 0, ctrlLoad, 0, 0, ACT_LOAD,   0, 0, 0);
        applyStimulus(0, 1, 32'h10C, 5, 2, 6, 1, 1, ctrlAlu,  0, 0, ACT_BUBBLE, 1, 1, 0);
        applyStimulus(0, 1, 32'h10C, 5, 2, 6, 1, 1, ctrlAlu,  0, 0, ACT_LOAD,   0, 1, 0);
        // load to x0 is never a hazard
        applyStimulus(0, 1, 32'h110, 1, 0, 0, 1, 0, ctrlLoad, 0, 0, ACT_LOAD,   0, 1, 0);
        applyStimulus(0, 1, 32'h114, 0, 2, 6, 1, 1, ctrlAlu,  0, 0, ACT_LOAD,   0, 1, 0);
        // matching rs2 field that is not actually read
        applyStimulus(0, 1, 32'h118, 1, 0, 5, 1, 0, ctrlLoad, 0, 0, ACT_LOAD,   0, 1, 0);
        applyStimulus(0, 1, 32'h11C, 7, 5, 8, 1, 0, ctrlAlu,  0, 0, ACT_LOAD,   0, 1, 0);
        // flush and load-use together: flush wins
        applyStimulus(0, 1, 32'h120, 1, 0, 5, 1, 0, ctrlLoad, 0, 0, ACT_LOAD,   0, 1, 0);
        applyStimulus(0, 1, 32'h124, 5, 2, 6, 1, 1, ctrlAlu,  1, 0, ACT_BUBBLE, 0, 1, 1);
        // idValid=0 loads data but zeroes control and addresses
        applyStimulus(0, 0, 32'h128, 3, 4, 9, 1, 1, ctrlAlu,  0, 0, ACT_LOADINV, 0, 1, 1);
        // memStall freeze: hazStall still visible, flush ignored
        applyStimulus(0, 1, 32'h12C, 1, 0, 5, 1, 0, ctrlLoad, 0, 0, ACT_LOAD,   0, 1, 1);
        applyStimulus(0, 1, 32'h130, 5, 2, 6, 1, 1, ctrlAlu,  0, 1, ACT_HOLD,   1, 1, 1);
        applyStimulus(0, 1, 32'h134, 5, 2, 6, 1, 1, ctrlAlu,  1, 1, ACT_HOLD,   0, 1, 1);
        applyStimulus(0, 1, 32'h138, 5, 9, 7, 1, 1, ctrlAlu,  1, 1, ACT_HOLD,   0, 1, 1);
        applyStimulus(0, 1, 32'h13C, 5, 2, 6, 1, 1, ctrlAlu,  1, 1, ACT_HOLD,   0, 1, 1);
        applyStimulus(0, 1, 32'h140, 5, 2, 6, 1, 1, ctrlAlu,  1, 0, ACT_BUBBLE, 0, 1, 2);
        // repeated load-use events drive the 2-bit instance into saturation
        st = 1;
        fc = 2;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 32'h200 + 16 * i, 1, 0, 5, 1, 0, ctrlLoad, 0, 0, ACT_LOAD, 0, st, fc);
            st++;
            applyStimulus(0, 1, 32'h204 + 16 * i, 2, 5, 6, 1, 1, ctrlAlu, 0, 0, ACT_BUBBLE, 1, st, fc);
            applyStimulus(0, 1, 32'h204 + 16 * i, 2, 5, 6, 1, 1, ctrlAlu, 0, 0, ACT_LOAD, 0, st, fc);
        end
        for (int i = 0; i < 2; i++) begin
            fc++;
            applyStimulus(0, 1, 32'h300 + 4 * i, 1, 2, 3, 1, 1, ctrlAlu, 1, 0, ACT_BUBBLE, 0, st, fc);
        end
        // reset in the middle of a load-use stall and a MEM freeze
        applyStimulus(0, 1, 32'h400, 1, 0, 5, 1, 0, ctrlLoad, 0, 0, ACT_LOAD,  0, st, fc);
        applyStimulus(1, 1, 32'h404, 5, 2, 6, 1, 1, ctrlAlu,  0, 1, ACT_RESET, 1, 0, 0);
        applyStimulus(0, 1, 32'h404, 5, 2, 6, 1, 1, ctrlAlu,  0, 0, ACT_LOAD,  0, 0, 0);
        idValid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idex_reg.md
Name: idex_reg

Overview:
ID/EX pipeline register for the RV32I 5-stage core, with integrated load-use hazard detection. It captures decoded operands, immediate, register addresses and control from ID, and presents them to EX. The EX-stage forwarding unit consumes the idexRs1/idexRs2 outputs. When forwarding cannot resolve a hazard (load followed by a dependent instruction), this block inserts a bubble and stalls PC and IF/ID. It also honours branch flushes from EX and whole-pipe holds from MEM, and keeps saturating stall and flush counters.

Parameters:
XLEN, 32, datapath width
RF_ADDR_WIDTH, `RF_ADDR_WIDTH (5), register-file address width
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
idValid  in  1  ID holds a real instruction
idPc  in  XLEN  PC of the ID instruction
idRs1Data, idRs2Data  in  XLEN  register-file read data
idImm  in  XLEN  sign-extended immediate
idRs1, idRs2, idRd  in  RF_ADDR_WIDTH  register addresses
idUsesRs1, idUsesRs2  in  1  the instruction actually reads rs1/rs2
idCtrl  in  idex_ctrl_t  decoded control (regWrite, memRead, memWrite, memToReg, aluSrc, branch, jump, aluOp[3:0])
exFlush  in  1  branch/jump taken in EX; kill the ID instruction
memStall  in  1  MEM busy; freeze this register
idexValid  out  1  EX holds a real instruction
idexPc, idexRs1Data, idexRs2Data, idexImm  out  XLEN  registered copies
idexRs1, idexRs2, idexRd  out  RF_ADDR_WIDTH  registered addresses
idexCtrl  out  idex_ctrl_t  registered control
hazStall  out  1  combinational; hold PC and IF/ID
stallCount, flushCount  out  CNT_WIDTH  saturating event counters

Behaviour:
- Reset (rst=1 at a clk edge): all registered outputs go to 0 (idexValid=0, idexCtrl all-zero, addresses 0, data 0), counters go to 0. Reset overrides everything.
- loadUse is combinational and equals 1 when all of these hold:
  - idValid && idexValid && idexCtrl.memRead && idexRd!=0
  - (idUsesRs1 && idRs1==idexRd) || (idUsesRs2 && idRs2==idexRd)
- hazStall = loadUse && !exFlush. It is a pure function of current inputs and registers, and is asserted even while memStall=1.
- Per-edge action, in priority order:
  1. rst: reset as above.
  2. memStall: hold every register unchanged; exFlush is ignored. EX must keep exFlush asserted until memStall drops.
  3. exFlush: load a bubble; flushCount += 1.
  4. loadUse: load a bubble; stallCount += 1.
  5. Otherwise: load all id* fields; idexValid <= idValid.
- Bubble contents: idexValid=0, idexCtrl=0 (so no regWrite/memRead/memWrite), idexRs1=idexRs2=idexRd=0 so the forwarding unit never matches, data fields 0.
- If idValid=0 in the normal path, the fields still load, but idexCtrl is forced to 0 and addresses are forced to 0.
- Latency: one cycle from ID to EX. A load-use hazard costs exactly one bubble; on the next cycle the load has moved to MEM and loadUse deasserts.
- Counters saturate at all-ones and never wrap.
- Flush and load-use in the same cycle: flush wins, hazStall=0, only flushCount increments.
- Reset mid-stall: the next cycle has idexValid=0 and hazStall=0.

Decomposition:
- Add to the shared package / rv32i_defs.sv:
  - the packed struct idex_ctrl_t
  - the aluOp enum
  - the IDEX_BUBBLE constant (all-zero ctrl)
- One sub-module: idex_hazard, the combinational loadUse/hazStall detector. It is reusable by a future branch-in-ID hazard check.
- Counters stay inline.

Test Plan:
- Back-to-back independent ALU ops (x1=x2+x3, then x4=x5+x6) -> each appears on idex* one cycle later; hazStall=0; counters stay 0.
- lw x5,0(x1) then add x6,x5,x2 -> hazStall=1 for one cycle; the next idex is a bubble (idexValid=0, idexRd=0); then the add loads; stallCount=1.
- lw x0,0(x1) then add x6,x0,x2, and lw x5 then an instruction with idUsesRs2=0 and idRs2=5 -> no stall in either case.
- exFlush=1 while ID holds a load-use-dependent add -> bubble loaded; hazStall=0; flushCount=1; stallCount=0.
- memStall=1 for 3 cycles with exFlush=1 and new id* inputs -> idex* unchanged and counters unchanged; when memStall drops with exFlush=1, a bubble loads and flushCount=1.
- Force stallCount to 0xFFFE, then drive three load-use events -> the counter reads 0xFFFF and stays there; rst then clears all outputs to 0.
